// File: rtl/store_pkg.sv
// store_pkg: store type encodings, buffer entry layout and the register-to-lane narrowing helper.
package store_pkg;
  typedef enum logic [1:0] {ST_SW = 2'd0, ST_SH = 2'd1, ST_SB = 2'd2, ST_RSV = 2'd3} st_type_e;
  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } lane_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } entry_t;
  // Reserved type behaves as SW; misaligned low offset bits are ignored here.
  function automatic lane_t narrow(st_type_e t, logic [1:0] off, logic [31:0] wdata);
    lane_t r;
    r.be   = (t == ST_SB) ? 4'b0001 << off : (t == ST_SH) ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
    r.data = (t == ST_SB) ? {4{wdata[7:0]}} : (t == ST_SH) ? {2{wdata[15:0]}} : wdata;
    return r;
  endfunction
endpackage

// File: rtl/store_fifo.sv
// store_fifo: generic DEPTH x W synchronous FIFO with count/full/empty; head is presented combinationally.
module store_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign full    = cnt_q == (PW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign cnt_d   = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/store_narrow_buffer.sv
// store_narrow_buffer: narrows SW/SH/SB stores to byte lanes and queues them toward data memory.
// Define STORE_MISALIGN_EXC_EN to reject misaligned SW/SH with an st_exc pulse instead of aligning them.
module store_narrow_buffer
  import store_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [1:0]    st_type,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_wdata,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          st_exc
);
  localparam int W = AW + $bits(lane_t);
  st_type_e              typ;
  logic [1:0]            off;
  lane_t                 lane;
  logic                  mis, full, empty;
  logic [$clog2(DEPTH):0] count;
  logic [W-1:0]          din, head;
  assign typ  = st_type_e'(st_type);
  assign off  = st_addr[1:0];
  assign lane = narrow(typ, off, st_wdata);
  assign din  = {st_addr[AW-1:2], 2'b00, lane};
`ifdef STORE_MISALIGN_EXC_EN
  assign mis    = (typ == ST_SH) ? off[0] : (typ != ST_SB) && (off != 2'b00);
  assign st_exc = !reset && st_valid && st_ready && mis;
`else
  assign mis    = 1'b0;
  assign st_exc = 1'b0;
`endif
  store_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (st_valid && !mis),
    .pop   (mem_ready),
    .din   (din),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  assign st_ready                      = !full;
  assign mem_valid                     = !empty;
  assign busy                          = count != '0;
  assign {mem_addr, mem_be, mem_wdata} = head;
endmodule

// File: tb/tb_store_narrow_buffer.sv
// tb_store_narrow_buffer: directed plus randomized checks against a queue-based store buffer model.
module tb_store_narrow_buffer;
  localparam int DEPTH = 2;
  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } ent_t;
  logic        clk = 1'b0, reset = 1'b1;
  logic        st_valid = 1'b0, st_ready, mem_valid, mem_ready = 1'b0, busy, st_exc;
  logic [1:0]  st_type = 2'd0;
  logic [31:0] st_addr = '0, st_wdata = '0, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  int          n_chk = 0, n_pass = 0;
  ent_t        q[$];
  always #5 clk = ~clk;
  store_narrow_buffer #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready), .st_type(st_type),
    .st_addr(st_addr), .st_wdata(st_wdata), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .busy(busy), .st_exc(st_exc)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask
  // Byte b is enabled when it falls in the same size-aligned group as the offset; data repeats per group.
  function automatic void ref_narrow(input logic [1:0] t, input logic [1:0] off, input logic [31:0] w,
                                     output logic [3:0] be, output logic [31:0] d, output logic mis);
    int sz;
    sz  = (t == 2'd1) ? 2 : (t == 2'd2) ? 1 : 4;
    mis = (int'(off) % sz) != 0;
    for (int b = 0; b < 4; b++) begin
      be[b]       = (b / sz) == (int'(off) / sz);
      d[8*b +: 8] = w[8*(b % sz) +: 8];
    end
  endfunction
  task automatic step(input logic v, input logic [1:0] t, input logic [31:0] a, input logic [31:0] w,
                      input logic rdy, input logic rs);
    logic [3:0]  be;
    logic [31:0] d;
    logic        mis, exp_rdy, do_pop, do_push, rej;
    @(negedge clk);
    st_valid = v; st_type = t; st_addr = a; st_wdata = w; mem_ready = rdy; reset = rs;
    #1;
    ref_narrow(t, a[1:0], w, be, d, mis);
`ifdef STORE_MISALIGN_EXC_EN
    rej = mis;
`else
    rej = 1'b0;
`endif
    if (rs) q.delete();
    else begin
      exp_rdy = q.size() != DEPTH;
      chk("st_ready", st_ready, exp_rdy);
      chk("mem_valid", mem_valid, q.size() != 0);
      chk("busy", busy, q.size() != 0);
      chk("st_exc", st_exc, v && exp_rdy && rej);
      if (q.size() != 0) begin
        chk("mem_addr", mem_addr, q[0].a);
        chk("mem_be", mem_be, q[0].be);
        chk("mem_wdata", mem_wdata, q[0].d);
      end
      do_pop  = rdy && q.size() != 0;
      do_push = v && exp_rdy && !rej;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{a: {a[31:2], 2'b00}, be: be, d: d});
    end
  endtask
  initial begin
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_be", mem_be, 4'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    step(1, 2, 32'h1003, 32'h0000_00AB, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("t1_addr", mem_addr, 32'h1000);
    chk("t1_be", mem_be, 4'b1000);
    chk("t1_data", mem_wdata, 32'hABAB_ABAB);
    step(0, 0, 0, 0, 1, 0);
    chk("t1_drained", mem_valid, 1'b0);
    step(1, 1, 32'h2002, 32'h1234_CDEF, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("t2_addr", mem_addr, 32'h2000);
    chk("t2_be", mem_be, 4'b1100);
    chk("t2_data", mem_wdata, 32'hCDEF_CDEF);
    step(1, 0, 32'h10, 32'h1111_1111, 0, 0);
    step(1, 0, 32'h14, 32'h2222_2222, 0, 0);
    step(1, 0, 32'h18, 32'h3333_3333, 1, 0);
    chk("t3_full", st_ready, 1'b0);
    chk("t3_head", mem_addr, 32'h10);
    step(0, 0, 0, 0, 1, 0);
    chk("t3_second", mem_addr, 32'h14);
    chk("t3_ready", st_ready, 1'b1);
    step(0, 0, 0, 0, 1, 0);
    step(1, 2, 32'h40, 32'h55, 0, 0);
    step(1, 0, 32'h44, 32'hDEAD_BEEF, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t4_head", mem_addr, 32'h44);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 32'h50, 32'h5, 0, 0);
    step(1, 0, 32'h54, 32'h6, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    chk("t5_valid", mem_valid, 1'b0);
    chk("t5_ready", st_ready, 1'b1);
    step(1, 1, 32'h3001, 32'hAAAA_1234, 1, 0);
    step(0, 0, 0, 0, 1, 0);
`ifdef STORE_MISALIGN_EXC_EN
    chk("t6_nopush", mem_valid, 1'b0);
`else
    chk("t6_be", mem_be, 4'b0011);
    chk("t6_addr", mem_addr, 32'h3000);
`endif
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
    step(0, 0, 0, 0, 1, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
